// File: rtl/pkt_tx_builder_if.sv
// Valid/ready word stream from the packet builder towards the radio/MAC.
// The builder drives the master side; the MAC (or a bench) drives tx_ready.
interface pkt_tx_builder_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_last;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/pkt_tx_builder.sv
// EER-RL transmit packet builder: header/src/dest/energy/Q[/payload] words with sequence numbers
// and a periodic self-heartbeat. Define PKT_CHECKSUM_EN to append an XOR checksum word.
module pkt_tx_builder #(
  parameter int WORD_WIDTH = 16,
  parameter int HB_PERIOD  = 1000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  send_req,
  input  logic [2:0]            send_type,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] destinationID,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] payload,
  output logic                  busy,
  output logic                  req_err,
  output logic                  pkt_done,
  pkt_tx_builder_if.master      tx
);
  localparam int HB_W = $clog2(HB_PERIOD);
`ifdef PKT_CHECKSUM_EN
  localparam logic [4:0] LEN_CTRL = 5'd6;
  localparam logic [4:0] LEN_DATA = 5'd7;
`else
  localparam logic [4:0] LEN_CTRL = 5'd5;
  localparam logic [4:0] LEN_DATA = 5'd6;
`endif
  localparam logic [2:0] TYPE_HB   = 3'd0;
  localparam logic [2:0] TYPE_DATA = 3'd3;
  localparam logic [2:0] TYPE_MAX  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SRC, S_DST, S_ENERGY, S_QVAL, S_PAYLOAD
`ifdef PKT_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            seq_q, seq_d;
  logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
  logic                  hb_pend_q, hb_pend_d;
  logic [2:0]            type_q, type_d;
  logic [WORD_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [WORD_WIDTH-1:0] energy_q, energy_d, qval_q, qval_d, payload_q, payload_d;
  logic                  req_err_q, req_err_d, pkt_done_q, pkt_done_d;

  logic                  valid_w, last_w, is_data, hb_wrap, hb_due, req_legal, xfer;
  logic [WORD_WIDTH-1:0] header_w, word_w;

  // Word mux is purely a function of registered state, so data/last stay put during stalls.
  always_comb begin
    is_data  = (type_q == TYPE_DATA);
    header_w = WORD_WIDTH'({type_q, (is_data ? LEN_DATA : LEN_CTRL), seq_q});
    valid_w  = (state_q != S_IDLE);
    word_w   = '0;
    last_w   = 1'b0;
    case (state_q)
      S_HDR:     word_w = header_w;
      S_SRC:     word_w = src_q;
      S_DST:     word_w = dst_q;
      S_ENERGY:  word_w = energy_q;
      S_QVAL: begin
        word_w = qval_q;
`ifndef PKT_CHECKSUM_EN
        last_w = !is_data;
`endif
      end
      S_PAYLOAD: begin
        word_w = payload_q;
`ifndef PKT_CHECKSUM_EN
        last_w = 1'b1;
`endif
      end
`ifdef PKT_CHECKSUM_EN
      S_CSUM: begin
        word_w = header_w ^ src_q ^ dst_q ^ energy_q ^ qval_q ^ (is_data ? payload_q : '0);
        last_w = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    hb_wrap    = (hb_cnt_q == HB_W'(HB_PERIOD - 1));
    hb_due     = hb_pend_q | hb_wrap;
    req_legal  = send_req && (send_type <= TYPE_MAX);
    xfer       = valid_w && tx.tx_ready;
    state_d    = state_q;
    seq_d      = seq_q;
    hb_cnt_d   = hb_wrap ? '0 : hb_cnt_q + HB_W'(1);
    hb_pend_d  = hb_due;
    type_d     = type_q;
    src_d      = src_q;
    dst_d      = dst_q;
    energy_d   = energy_q;
    qval_d     = qval_q;
    payload_d  = payload_q;
    req_err_d  = 1'b0;
    pkt_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_err_d = send_req && !req_legal;
        // External request wins a collision; the due heartbeat stays pending behind it.
        if (req_legal || hb_due) begin
          state_d   = S_HDR;
          type_d    = req_legal ? send_type : TYPE_HB;
          src_d     = myNodeID;
          dst_d     = (type_d == TYPE_HB) ? '0 : destinationID;
          energy_d  = myEnergy;
          qval_d    = myQValue;
          payload_d = payload;
          if (type_d == TYPE_HB) begin
            hb_pend_d = 1'b0;
            hb_cnt_d  = '0;
          end
        end
      end
      default: begin
        if (xfer && last_w) begin
          state_d    = S_IDLE;
          seq_d      = seq_q + 8'd1;
          pkt_done_d = 1'b1;
        end else if (xfer) begin
          case (state_q)
            S_HDR:    state_d = S_SRC;
            S_SRC:    state_d = S_DST;
            S_DST:    state_d = S_ENERGY;
            S_ENERGY: state_d = S_QVAL;
`ifdef PKT_CHECKSUM_EN
            S_QVAL:    state_d = is_data ? S_PAYLOAD : S_CSUM;
            S_PAYLOAD: state_d = S_CSUM;
`else
            S_QVAL:    state_d = S_PAYLOAD;
`endif
            default:  state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      seq_q      <= '0;
      hb_cnt_q   <= '0;
      hb_pend_q  <= 1'b0;
      type_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      energy_q   <= '0;
      qval_q     <= '0;
      payload_q  <= '0;
      req_err_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_pend_q  <= hb_pend_d;
      type_q     <= type_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      energy_q   <= energy_d;
      qval_q     <= qval_d;
      payload_q  <= payload_d;
      req_err_q  <= req_err_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign tx.tx_valid = valid_w;
  assign tx.tx_data  = word_w;
  assign tx.tx_last  = last_w;
  assign busy        = valid_w;
  assign req_err     = req_err_q;
  assign pkt_done    = pkt_done_q;
endmodule
